// File: rtl/gcd_pkg.sv
// Shared types for the gcd request scheduler.
// Holds the FSM state enum, the data width and the job record.
package gcd_pkg;

   localparam int DATA_W    = 32;
   // Widest sequence tag a job record can carry; TAG_W must not exceed it.
   localparam int TAG_MAX_W = 16;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      OUT
   } sched_state_t;

   typedef struct packed {
      logic [DATA_W-1:0]    a;
      logic [DATA_W-1:0]    b;
      logic [TAG_MAX_W-1:0] tag;
   } job_t;

endpackage

// File: rtl/gcd_req_fifo.sv
// Synchronous FIFO for queued gcd jobs, no bypass.
// Ports: push_i/data_i write, pop_i/data_o read head, full_o/empty_o/count_o status.
module gcd_req_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic [W-1:0]             data_i,
   input  logic                     pop_i,
   output logic [W-1:0]             data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q, wr_d;
   logic [AW-1:0] rd_q, rd_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          push_ok;
   logic          pop_ok;

   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   assign data_o  = mem_q[rd_q];

   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   // DEPTH is a power of two, so pointers wrap by plain overflow.
   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (push_ok) wr_d = wr_q + AW'(1);
      if (pop_ok)  rd_d = rd_q + AW'(1);
      unique case ({push_ok, pop_ok})
         2'b10:   cnt_d = cnt_q + (AW+1)'(1);
         2'b01:   cnt_d = cnt_q - (AW+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_q] <= data_i;
   end

endmodule

// File: rtl/gcd_req_sched.sv
// Request scheduler: queues operand pairs, issues them one at a time to the
// gcd core, returns tagged results and aborts jobs the core never finishes.
// Ports: in_* operand stream, start_o/a_o/b_o/core_* core link, out_* results.
module gcd_req_sched #(
   parameter int DEPTH   = 4,
   parameter int TAG_W   = 4,
   parameter int TIMEOUT = 1024
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [31:0]      in_a_i,
   input  logic [31:0]      in_b_i,
   output logic             start_o,
   output logic [31:0]      a_o,
   output logic [31:0]      b_o,
   input  logic             core_busy_i,
   input  logic             core_valid_i,
   input  logic [31:0]      core_result_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [31:0]      out_result_o,
   output logic [TAG_W-1:0] out_tag_o,
   output logic             out_err_o
);

   import gcd_pkg::*;

   localparam int WD_W = $clog2(TIMEOUT) + 1;
   localparam int CW   = $clog2(DEPTH) + 1;

   sched_state_t      state_q, state_d;
   job_t              job_q, job_d;
   logic [WD_W-1:0]   wd_q, wd_d;
   logic [DATA_W-1:0] res_q, res_d;
   logic              err_q, err_d;
   logic [TAG_W-1:0]  tag_q, tag_d;

   job_t              fifo_in;
   job_t              fifo_head;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CW-1:0]     fifo_cnt;
   logic              push;
   logic              pop;

   assign in_ready_o = !fifo_full;
   assign push       = in_valid_i && !fifo_full;

   assign fifo_in.a   = in_a_i;
   assign fifo_in.b   = in_b_i;
   assign fifo_in.tag = TAG_MAX_W'(tag_q);

   gcd_req_fifo #(
      .DEPTH (DEPTH),
      .W     ($bits(job_t))
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push),
      .data_i  (fifo_in),
      .pop_i   (pop),
      .data_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_cnt)
   );

   a_fifo_cnt: assert property (@(posedge clk_i) disable iff (rst_i)
      fifo_empty == (fifo_cnt == '0));

   always_comb begin
      state_d = state_q;
      job_d   = job_q;
      wd_d    = wd_q;
      res_d   = res_q;
      err_d   = err_q;
      pop     = 1'b0;
      start_o = 1'b0;
      tag_d   = push ? tag_q + TAG_W'(1) : tag_q;
      unique case (state_q)
         IDLE: begin
            if (!fifo_empty && !core_busy_i) begin
               pop     = 1'b1;
               job_d   = fifo_head;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            start_o = 1'b1;
            wd_d    = '0;
            state_d = WAIT;
         end
         WAIT: begin
            wd_d = wd_q + WD_W'(1);
            // A result in the expiry cycle still counts as a success.
            if (core_valid_i) begin
               res_d   = core_result_i;
               err_d   = 1'b0;
               state_d = OUT;
            end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
               res_d   = '0;
               err_d   = 1'b1;
               state_d = OUT;
            end
         end
         OUT: begin
            if (out_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         job_q   <= '0;
         wd_q    <= '0;
         res_q   <= '0;
         err_q   <= 1'b0;
         tag_q   <= '0;
      end else begin
         state_q <= state_d;
         job_q   <= job_d;
         wd_q    <= wd_d;
         res_q   <= res_d;
         err_q   <= err_d;
         tag_q   <= tag_d;
      end
   end

   // Job register only changes on a pop, so a_o/b_o hold through WAIT.
   assign a_o          = job_q.a;
   assign b_o          = job_q.b;
   assign out_valid_o  = (state_q == OUT);
   assign out_result_o = res_q;
   assign out_tag_o    = TAG_W'(job_q.tag);
   assign out_err_o    = err_q;

endmodule
